// File: rtl/nsl_multi_session_if.sv
// NSL multi-session model: scheduler and intruder choice inputs,
// agent states, partners, FIFO occupancy and monitor outputs.
interface nsl_multi_session_if #(
  parameter int N_INIT = 2,
  parameter int N_RESP = 2,
  parameter int AW     = 3,
  parameter int KW     = 2,
  parameter int NW     = 1
);
  logic [AW-1:0]        selectS;
  logic [AW-1:0]        selectO;
  logic                 intercept;
  logic                 coin;
  logic [KW-1:0]        knowledge;
  logic [1:0]           message;
  logic [AW-1:0]        n1;
  logic [AW-1:0]        n2;
  logic [AW-1:0]        agent;
  logic [2*N_INIT-1:0]  a_state;
  logic [2*N_RESP-1:0]  b_state;
  logic [AW*N_INIT-1:0] a_partner;
  logic [AW*N_RESP-1:0] b_partner;
  logic [NW:0]          net_count;
  logic                 auth_violation;
  logic                 secrecy_leak;

  modport master (
    output selectS, selectO, intercept, coin,
    output knowledge, message, n1, n2, agent,
    input  a_state, b_state, a_partner, b_partner,
    input  net_count, auth_violation, secrecy_leak
  );

  modport slave (
    input  selectS, selectO, intercept, coin,
    input  knowledge, message, n1, n2, agent,
    output a_state, b_state, a_partner, b_partner,
    output net_count, auth_violation, secrecy_leak
  );
endinterface

// File: rtl/nsl_multi_session.sv
// NSL multi-session model: one agent acts per edge over a FIFO net.
// Ports: clock, reset_n (async low), bus (slave) with choices/outputs.
module nsl_multi_session #(
  parameter int N_INIT     = 2,
  parameter int N_RESP     = 2,
  parameter int N_INTR     = 1,
  parameter int AW         = 3,
  parameter int KNOW_DEPTH = 4,
  parameter int KW         = 2,
  parameter int NET_DEPTH  = 2,
  parameter int NW         = 1,
  parameter int LOWE_FIX   = 1
) (
  input  logic clock,
  input  logic reset_n,
  nsl_multi_session_if.slave bus
);
  localparam int NH = N_INIT + N_RESP;
  localparam int NA = NH + N_INTR;
  localparam int NV = 1 << AW;
  localparam int PW = (NW > 0) ? NW : 1;
  localparam int CW = NW + 1;

  typedef enum logic [1:0] {
    SLEEPING = 2'd0, WAITING = 2'd1, COMMITTED = 2'd2
  } st_e;

  typedef enum logic [1:0] {
    NONE = 2'd0, NONCE_ADDR = 2'd1,
    NONCE_NONCE_ADDR = 2'd2, NONCE = 2'd3
  } mt_e;

  typedef struct packed {
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW-1:0] key;
    mt_e           typ;
    logic [AW-1:0] n1;
    logic [AW-1:0] n2;
    logic [AW-1:0] addr;
  } msg_t;

  st_e           a_st_q [N_INIT], a_st_d [N_INIT];
  logic [AW-1:0] a_pt_q [N_INIT], a_pt_d [N_INIT];
  st_e           b_st_q [N_RESP], b_st_d [N_RESP];
  logic [AW-1:0] b_pt_q [N_RESP], b_pt_d [N_RESP];
  msg_t          net_q  [NET_DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  msg_t          mem_q  [N_INTR][KNOW_DEPTH];
  msg_t          mem_d  [N_INTR][KNOW_DEPTH];
  logic [KW-1:0] kp_q   [N_INTR], kp_d [N_INTR];
  logic [NV-1:0] know_q [N_INTR], know_d [N_INTR];
  logic          auth_q, auth_d, leak_q, leak_d;

  logic          pop, push, empty, full, from_intr;
  msg_t          pmsg, head;
  logic [AW-1:0] s, o;

  assign s         = bus.selectS;
  assign o         = bus.selectO;
  assign head      = net_q[rd_q];
  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CW'(NET_DEPTH));
  assign from_intr = int'(head.src) >= NH && int'(head.src) < NA;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(NET_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    a_st_d = a_st_q;
    a_pt_d = a_pt_q;
    b_st_d = b_st_q;
    b_pt_d = b_pt_q;
    mem_d  = mem_q;
    kp_d   = kp_q;
    know_d = know_q;
    pop    = 1'b0;
    push   = 1'b0;
    pmsg   = '0;
    for (int i = 0; i < N_INIT; i++) begin
      if (int'(s) == i) begin
        unique case (a_st_q[i])
          SLEEPING: begin
            if (int'(o) >= N_INIT && int'(o) < NA && !full) begin
              push = 1'b1;
              pmsg = '{src: AW'(i), dst: o, key: o,
                       typ: NONCE_ADDR, n1: AW'(i),
                       n2: AW'(i), addr: AW'(i)};
              a_st_d[i] = WAITING;
              a_pt_d[i] = o;
            end
          end
          WAITING: begin
            if (!empty && int'(head.dst) == i) begin
              pop = 1'b1;
              if (int'(head.key) == i &&
                  head.typ == NONCE_NONCE_ADDR &&
                  int'(head.n1) == i &&
                  (LOWE_FIX == 0 ||
                   head.addr == a_pt_q[i])) begin
                push = 1'b1;
                pmsg = '{src: AW'(i), dst: a_pt_q[i],
                         key: a_pt_q[i], typ: NONCE,
                         n1: head.n2, n2: '0,
                         addr: AW'(i)};
                a_st_d[i] = COMMITTED;
              end
            end
          end
          default: ;
        endcase
      end
    end
    for (int j = 0; j < N_RESP; j++) begin
      if (int'(s) == N_INIT + j && !empty &&
          head.dst == s) begin
        unique case (b_st_q[j])
          SLEEPING: begin
            pop = 1'b1;
            if (head.key == s && head.typ == NONCE_ADDR) begin
              push = 1'b1;
              pmsg = '{src: s, dst: head.n2, key: head.n2,
                       typ: NONCE_NONCE_ADDR, n1: head.n1,
                       n2: s,
                       addr: (LOWE_FIX != 0) ? s : '0};
              b_st_d[j] = WAITING;
              b_pt_d[j] = head.n2;
            end
          end
          WAITING: begin
            pop = 1'b1;
            if (head.key == s && head.typ == NONCE &&
                head.n1 == s)
              b_st_d[j] = COMMITTED;
          end
          default: ;
        endcase
      end
    end
    for (int k = 0; k < N_INTR; k++) begin
      if (int'(s) == NH + k) begin
        if (!empty && !from_intr) begin
          // Own-key traffic is decrypted; anything else is kept
          // verbatim in a ring for later replay.
          if (head.key == s) begin
            know_d[k][head.n1] = 1'b1;
            if (head.typ == NONCE_NONCE_ADDR)
              know_d[k][head.n2] = 1'b1;
          end else begin
            mem_d[k][kp_q[k]] = head;
            kp_d[k] = kp_q[k] + KW'(1);
          end
          pop = bus.intercept;
        end else if (!full && int'(o) < NH) begin
          if (bus.coin) begin
            if (mem_q[k][bus.knowledge].typ != NONE) begin
              push = 1'b1;
              pmsg = mem_q[k][bus.knowledge];
              pmsg.src = s;
              pmsg.dst = o;
            end
          end else if (int'(bus.n1) < NA &&
                       int'(bus.n2) < NA &&
                       int'(bus.agent) < NA &&
                       bus.message != 2'd0 &&
                       know_q[k][bus.n1] &&
                       know_q[k][bus.n2]) begin
            push = 1'b1;
            pmsg = '{src: s, dst: o, key: o,
                     typ: mt_e'(bus.message), n1: bus.n1,
                     n2: (bus.message == 2'd2) ?
                         bus.n2 : bus.agent,
                     addr: bus.agent};
          end
        end
      end
    end
  end

  always_comb begin
    auth_d = auth_q;
    leak_d = leak_q;
    for (int j = 0; j < N_RESP; j++) begin
      if (b_st_q[j] == COMMITTED &&
          int'(b_pt_q[j]) < N_INIT) begin
        for (int i = 0; i < N_INIT; i++) begin
          if (int'(b_pt_q[j]) == i &&
              !(int'(a_pt_q[i]) == N_INIT + j &&
                a_st_q[i] != SLEEPING))
            auth_d = 1'b1;
        end
        for (int k = 0; k < N_INTR; k++) begin
          if (know_q[k][N_INIT + j])
            leak_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_INIT; i++) begin
        a_st_q[i] <= SLEEPING;
        a_pt_q[i] <= '0;
      end
      for (int j = 0; j < N_RESP; j++) begin
        b_st_q[j] <= SLEEPING;
        b_pt_q[j] <= '0;
      end
      for (int e = 0; e < NET_DEPTH; e++)
        net_q[e] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int k = 0; k < N_INTR; k++) begin
        for (int e = 0; e < KNOW_DEPTH; e++)
          mem_q[k][e] <= '0;
        kp_q[k]           <= '0;
        know_q[k]         <= '0;
        know_q[k][NH + k] <= 1'b1;
      end
      auth_q <= 1'b0;
      leak_q <= 1'b0;
    end else begin
      a_st_q <= a_st_d;
      a_pt_q <= a_pt_d;
      b_st_q <= b_st_d;
      b_pt_q <= b_pt_d;
      mem_q  <= mem_d;
      kp_q   <= kp_d;
      know_q <= know_d;
      auth_q <= auth_d;
      leak_q <= leak_d;
      if (pop)
        rd_q <= nxt(rd_q);
      if (push) begin
        net_q[wr_q] <= pmsg;
        wr_q        <= nxt(wr_q);
      end
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    bus.a_state   = '0;
    bus.a_partner = '0;
    bus.b_state   = '0;
    bus.b_partner = '0;
    for (int i = 0; i < N_INIT; i++) begin
      bus.a_state[2*i +: 2]    = a_st_q[i];
      bus.a_partner[AW*i +: AW] = a_pt_q[i];
    end
    for (int j = 0; j < N_RESP; j++) begin
      bus.b_state[2*j +: 2]    = b_st_q[j];
      bus.b_partner[AW*j +: AW] = b_pt_q[j];
    end
  end

  assign bus.net_count      = cnt_q;
  assign bus.auth_violation = auth_q;
  assign bus.secrecy_leak   = leak_q;
endmodule

// File: tb/tb_nsl_multi_session.sv
// Bench for nsl_multi_session: original and fixed protocol side by
// side, checked every cycle against a queue-based protocol model.
module tb_nsl_multi_session;
  logic       clock = 1'b0;
  logic       rst_n;
  logic [2:0] sS, sO, f1, f2, ag;
  logic       ic, cn;
  logic [1:0] kn, mg;
  int         n_chk = 0;
  int         n_fail = 0;
  bit         en = 0;

  always #5 clock = ~clock;

  nsl_multi_session_if bus0 ();
  nsl_multi_session_if bus1 ();

  assign bus0.selectS = sS;  assign bus1.selectS = sS;
  assign bus0.selectO = sO;  assign bus1.selectO = sO;
  assign bus0.intercept = ic; assign bus1.intercept = ic;
  assign bus0.coin = cn;     assign bus1.coin = cn;
  assign bus0.knowledge = kn; assign bus1.knowledge = kn;
  assign bus0.message = mg;  assign bus1.message = mg;
  assign bus0.n1 = f1;       assign bus1.n1 = f1;
  assign bus0.n2 = f2;       assign bus1.n2 = f2;
  assign bus0.agent = ag;    assign bus1.agent = ag;

  nsl_multi_session #(.LOWE_FIX(0)) d0 (
    .clock(clock), .reset_n(rst_n), .bus(bus0));
  nsl_multi_session #(.LOWE_FIX(1)) d1 (
    .clock(clock), .reset_n(rst_n), .bus(bus1));

  typedef struct {
    int src; int dst; int key; int typ;
    int n1; int n2; int addr;
  } m_t;

  int  ma_st [2][2];
  int  ma_pt [2][2];
  int  mb_st [2][2];
  int  mb_pt [2][2];
  m_t  mnet  [2][$];
  m_t  mmem  [2][4];
  int  mkp   [2];
  bit  mknow [2][8];
  bit  mauth [2];
  bit  mleak [2];

  task automatic check(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 2; i++) begin
        ma_st[m][i] = 0; ma_pt[m][i] = 0;
        mb_st[m][i] = 0; mb_pt[m][i] = 0;
      end
      mnet[m].delete();
      for (int e = 0; e < 4; e++)
        mmem[m][e] = '{0, 0, 0, 0, 0, 0, 0};
      mkp[m] = 0;
      for (int v = 0; v < 8; v++) mknow[m][v] = (v == 4);
      mauth[m] = 0;
      mleak[m] = 0;
    end
  endfunction

  // Agents 0,1 initiators; 2,3 responders; 4 intruder.
  function automatic void mstep(int m);
    int S, O, n, p;
    bit pop, push;
    m_t h, pm, junk;
    S = int'(sS); O = int'(sO);
    n = mnet[m].size();
    pop = 0; push = 0;
    h = '{0, 0, 0, 0, 0, 0, 0};
    pm = h;
    for (int r = 0; r < 2; r++) begin
      if (mb_st[m][r] == 2 && mb_pt[m][r] < 2) begin
        p = mb_pt[m][r];
        if (!(ma_pt[m][p] == r + 2 && ma_st[m][p] != 0))
          mauth[m] = 1;
        if (mknow[m][r + 2]) mleak[m] = 1;
      end
    end
    if (n > 0) h = mnet[m][0];
    if (S < 2) begin
      if (ma_st[m][S] == 0) begin
        if (O >= 2 && O < 5 && n < 2) begin
          push = 1;
          pm = '{S, O, O, 1, S, S, S};
          ma_st[m][S] = 1;
          ma_pt[m][S] = O;
        end
      end else if (ma_st[m][S] == 1 && n > 0 && h.dst == S) begin
        pop = 1;
        if (h.key == S && h.typ == 2 && h.n1 == S &&
            (m == 0 || h.addr == ma_pt[m][S])) begin
          push = 1;
          pm = '{S, ma_pt[m][S], ma_pt[m][S], 3, h.n2, 0, S};
          ma_st[m][S] = 2;
        end
      end
    end else if (S < 4) begin
      if (n > 0 && h.dst == S) begin
        if (mb_st[m][S-2] == 0) begin
          pop = 1;
          if (h.key == S && h.typ == 1) begin
            push = 1;
            pm = '{S, h.n2, h.n2, 2, h.n1, S, (m == 1) ? S : 0};
            mb_st[m][S-2] = 1;
            mb_pt[m][S-2] = h.n2;
          end
        end else if (mb_st[m][S-2] == 1) begin
          pop = 1;
          if (h.key == S && h.typ == 3 && h.n1 == S)
            mb_st[m][S-2] = 2;
        end
      end
    end else if (S == 4) begin
      if (n > 0 && h.src != 4) begin
        if (h.key == 4) begin
          mknow[m][h.n1] = 1;
          if (h.typ == 2) mknow[m][h.n2] = 1;
        end else begin
          mmem[m][mkp[m]] = h;
          mkp[m] = (mkp[m] + 1) % 4;
        end
        pop = ic;
      end else if (n < 2 && O < 4) begin
        if (cn) begin
          if (mmem[m][kn].typ != 0) begin
            push = 1;
            pm = mmem[m][kn];
            pm.src = 4;
            pm.dst = O;
          end
        end else if (f1 < 5 && f2 < 5 && ag < 5 && mg != 0 &&
                     mknow[m][f1] && mknow[m][f2]) begin
          push = 1;
          pm = '{4, O, O, int'(mg), int'(f1),
                 (mg == 2) ? int'(f2) : int'(ag), int'(ag)};
        end
      end
    end
    if (pop) junk = mnet[m].pop_front();
    if (push) mnet[m].push_back(pm);
  endfunction

  always @(negedge clock) begin
    int eas, ebs, eap, ebp;
    if (en) begin
      for (int m = 0; m < 2; m++) begin
        eas = 0; ebs = 0; eap = 0; ebp = 0;
        for (int i = 0; i < 2; i++) begin
          eas |= ma_st[m][i] << (2 * i);
          ebs |= mb_st[m][i] << (2 * i);
          eap |= ma_pt[m][i] << (3 * i);
          ebp |= mb_pt[m][i] << (3 * i);
        end
        check($sformatf("d%0d a_state", m),
          int'(m ? bus1.a_state : bus0.a_state), eas);
        check($sformatf("d%0d b_state", m),
          int'(m ? bus1.b_state : bus0.b_state), ebs);
        check($sformatf("d%0d a_partner", m),
          int'(m ? bus1.a_partner : bus0.a_partner), eap);
        check($sformatf("d%0d b_partner", m),
          int'(m ? bus1.b_partner : bus0.b_partner), ebp);
        check($sformatf("d%0d net_count", m),
          int'(m ? bus1.net_count : bus0.net_count),
          mnet[m].size());
        check($sformatf("d%0d auth", m),
          int'(m ? bus1.auth_violation : bus0.auth_violation),
          int'(mauth[m]));
        check($sformatf("d%0d leak", m),
          int'(m ? bus1.secrecy_leak : bus0.secrecy_leak),
          int'(mleak[m]));
      end
    end
  end

  task automatic cyc(int s, int o, bit i = 0, bit c = 0,
                     int k = 0, int g = 0, int a1 = 0,
                     int a2 = 0, int a = 0);
    sS = 3'(s); sO = 3'(o); ic = i; cn = c;
    kn = 2'(k); mg = 2'(g);
    f1 = 3'(a1); f2 = 3'(a2); ag = 3'(a);
    @(posedge clock);
    if (rst_n) begin
      mstep(0);
      mstep(1);
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    cyc(7, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    sS = 3'd7; sO = '0; ic = 0; cn = 0; kn = '0;
    mg = '0; f1 = '0; f2 = '0; ag = '0;
    @(posedge clock); #1;
    en = 1;
    cyc(7, 0);
    rst_n = 1'b1;
    check("rst a_state", int'(bus1.a_state), 0);
    check("rst net_count", int'(bus0.net_count), 0);
    check("rst auth", int'(bus0.auth_violation), 0);

    // honest run
    cyc(0, 2); cyc(2, 0); cyc(0, 0); cyc(2, 0);
    check("hon A0", int'(bus1.a_state[1:0]), 2);
    check("hon B2", int'(bus1.b_state[1:0]), 2);
    check("hon a_partner0", int'(bus1.a_partner[2:0]), 2);
    check("hon b_partner2", int'(bus1.b_partner[2:0]), 0);
    check("hon net_count", int'(bus1.net_count), 0);
    cyc(7, 0);
    check("hon auth", int'(bus1.auth_violation), 0);
    check("hon leak", int'(bus1.secrecy_leak), 0);
    do_reset();

    // FIFO full behaviour
    cyc(0, 2); cyc(1, 3);
    check("full count", int'(bus0.net_count), 2);
    cyc(4, 2, 0, 0, 0, 1, 4, 4, 4);
    check("full blocked", int'(bus0.net_count), 2);
    cyc(2, 0);
    check("pop push count", int'(bus0.net_count), 2);
    check("pop push B2", int'(bus0.b_state[1:0]), 1);
    do_reset();

    // intruder ring wraps; slot 0 then holds the 5th record
    cyc(0, 2); cyc(4, 0); cyc(1, 3); cyc(4, 0, 1);
    cyc(4, 0); cyc(4, 0); cyc(3, 0); cyc(4, 0, 1);
    cyc(4, 1, 0, 1, 0);
    check("replay push", int'(bus1.net_count), 1);
    cyc(1, 0);
    check("replay A1 d1", int'(bus1.a_state[3:2]), 2);
    check("replay A1 d0", int'(bus0.a_state[3:2]), 2);
    do_reset();

    // Lowe attack, both modes at once
    cyc(0, 4); cyc(4, 4, 1);
    cyc(4, 2, 0, 0, 0, 1, 0, 0, 0);
    cyc(2, 0); cyc(0, 0); cyc(4, 4, 1);
    cyc(4, 2, 0, 0, 0, 3, 2, 2, 0);
    cyc(2, 0);
    check("atk B2 d0", int'(bus0.b_state[1:0]), 2);
    check("atk auth early", int'(bus0.auth_violation), 0);
    cyc(7, 0);
    check("atk auth", int'(bus0.auth_violation), 1);
    check("atk leak", int'(bus0.secrecy_leak), 1);
    check("atk b_partner2", int'(bus0.b_partner[2:0]), 0);
    check("atk a_partner0", int'(bus0.a_partner[2:0]), 4);
    check("fix A0", int'(bus1.a_state[1:0]), 1);
    check("fix B2", int'(bus1.b_state[1:0]), 1);
    check("fix auth", int'(bus1.auth_violation), 0);
    check("fix leak", int'(bus1.secrecy_leak), 0);
    cyc(1, 3);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst count", int'(bus0.net_count), 0);
    check("arst auth", int'(bus0.auth_violation), 0);
    check("arst leak", int'(bus0.secrecy_leak), 0);
    check("arst b_state", int'(bus0.b_state), 0);
    check("arst a_partner", int'(bus0.a_partner), 0);
    cyc(7, 0);
    rst_n = 1'b1;
    cyc(4, 2, 0, 0, 0, 1, 0, 0, 0);
    check("arst knowledge", int'(bus0.net_count), 0);

    // random traffic
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      cyc(($urandom_range(0, 2) == 0) ? 4 : $urandom_range(0, 7),
          $urandom_range(0, 7), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 5),
          $urandom_range(0, 5), $urandom_range(0, 5));
    end
    @(negedge clock); #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
